// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: in-flight destination scoreboard, RAW forward/stall
// decisions for both source operands, mult/div busy FSM and a saturating stall counter.
module decode_hazard_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_wr_en,
   input  logic [4:0]       id_wr_reg,
   input  logic             id_is_load,
   input  logic             id_is_muldiv,
   input  logic             id_reads_hilo,
   output logic             stall,
   output logic             ex_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

   // A WB-stage result is always forwardable, so WB keeps no load flag.
   logic             ex_valid_q, ex_valid_d;
   logic [4:0]       ex_reg_q, ex_reg_d;
   logic             ex_load_q, ex_load_d;
   logic             mem_valid_q, mem_valid_d;
   logic [4:0]       mem_reg_q, mem_reg_d;
   logic             mem_load_q, mem_load_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_reg_q, wb_reg_d;
   md_state_t        md_state_q, md_state_d;
   logic [3:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic             rs_hazard, rt_hazard, md_hazard, stall_int;
   logic [1:0]       rs_sel, rt_sel;

   function automatic logic [2:0] check_operand(
      input logic       en,
      input logic [4:0] x,
      input logic       exv,
      input logic [4:0] exr,
      input logic       memv,
      input logic [4:0] memr,
      input logic       meml,
      input logic       wbv,
      input logic [4:0] wbr
   );
      logic       hz;
      logic [1:0] sel;
      hz  = 1'b0;
      sel = 2'd0;
      if (en && (x != 5'd0)) begin
         if (exv && (exr == x)) begin
            hz = 1'b1;
         end else if (memv && (memr == x) && meml) begin
            hz = 1'b1;
         end else if (memv && (memr == x)) begin
            sel = 2'd1;
         end else if (wbv && (wbr == x)) begin
            sel = 2'd2;
         end
      end
      return {hz, sel};
   endfunction

   always_comb begin
      {rs_hazard, rs_sel} = check_operand(id_valid & id_uses_rs, rs,
                                          ex_valid_q, ex_reg_q,
                                          mem_valid_q, mem_reg_q, mem_load_q,
                                          wb_valid_q, wb_reg_q);
      {rt_hazard, rt_sel} = check_operand(id_valid & id_uses_rt, rt,
                                          ex_valid_q, ex_reg_q,
                                          mem_valid_q, mem_reg_q, mem_load_q,
                                          wb_valid_q, wb_reg_q);
      md_hazard = (md_state_q == MD_BUSY) & id_valid & (id_is_muldiv | id_reads_hilo);
      stall_int = rs_hazard | rt_hazard | md_hazard;
   end

   always_comb begin
      ex_valid_d  = id_valid & id_wr_en & ~stall_int;
      ex_reg_d    = id_wr_reg;
      ex_load_d   = id_is_load;
      mem_valid_d = ex_valid_q;
      mem_reg_d   = ex_reg_q;
      mem_load_d  = ex_load_q;
      wb_valid_d  = mem_valid_q;
      wb_reg_d    = mem_reg_q;

      md_state_d = md_state_q;
      md_cnt_d   = md_cnt_q;
      case (md_state_q)
         MD_IDLE: begin
            if (id_valid && id_is_muldiv && !stall_int) begin
               md_state_d = MD_BUSY;
               md_cnt_d   = MD_INIT;
            end
         end
         MD_BUSY: begin
            if (md_cnt_q == 4'd0) begin
               md_state_d = MD_IDLE;
            end else begin
               md_cnt_d = md_cnt_q - 4'd1;
            end
         end
         default: begin
            md_state_d = MD_IDLE;
            md_cnt_d   = 4'd0;
         end
      endcase

      stall_count_d = stall_count_q;
      if (stall_int && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         ex_reg_q      <= 5'd0;
         ex_load_q     <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_reg_q     <= 5'd0;
         mem_load_q    <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_reg_q      <= 5'd0;
         md_state_q    <= MD_IDLE;
         md_cnt_q      <= 4'd0;
         stall_count_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_reg_q      <= ex_reg_d;
         ex_load_q     <= ex_load_d;
         mem_valid_q   <= mem_valid_d;
         mem_reg_q     <= mem_reg_d;
         mem_load_q    <= mem_load_d;
         wb_valid_q    <= wb_valid_d;
         wb_reg_q      <= wb_reg_d;
         md_state_q    <= md_state_d;
         md_cnt_q      <= md_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Outputs are held quiet for the whole reset pulse, not just after the first edge.
   assign stall       = stall_int & ~reset;
   assign ex_bubble   = stall_int & ~reset;
   assign fwd_a_sel   = reset ? 2'd0 : rs_sel;
   assign fwd_b_sel   = reset ? 2'd0 : rt_sel;
   assign md_busy     = (md_state_q == MD_BUSY) & ~reset;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: an age-ordered in-flight list plus a busy
// countdown model is compared every cycle, with hand-computed literals pinning key points.
module tb_decode_hazard_ctrl;

   localparam int MD_LATENCY = 4;
   localparam int CNT_W      = 4;
   localparam int SC_MAX     = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             id_valid;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_wr_en;
   logic [4:0]       id_wr_reg;
   logic             id_is_load;
   logic             id_is_muldiv;
   logic             id_reads_hilo;
   logic             stall;
   logic             ex_bubble;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             md_busy;
   logic [CNT_W-1:0] stall_count;

   decode_hazard_ctrl #(
      .MD_LATENCY(MD_LATENCY),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .rs           (rs),
      .rt           (rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_wr_en     (id_wr_en),
      .id_wr_reg    (id_wr_reg),
      .id_is_load   (id_is_load),
      .id_is_muldiv (id_is_muldiv),
      .id_reads_hilo(id_reads_hilo),
      .stall        (stall),
      .ex_bubble    (ex_bubble),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .md_busy      (md_busy),
      .stall_count  (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: inflight[age] holds the instruction issued age+1 cycles ago (0 = youngest).
   typedef struct packed {
      logic       v;
      logic [4:0] r;
      logic       ld;
   } ent_t;

   ent_t inflight [3];
   int   busyLeft;
   int   scModel;
   int   vectors;
   int   miscompares;

   // Youngest matching producer decides: too young (or a load one stage out) stalls, else forward by age.
   function automatic logic [2:0] opScan(input logic use_x, input logic [4:0] x);
      if (!(id_valid && use_x && (x != 5'd0))) return 3'b000;
      for (int age = 0; age < 3; age++) begin
         if (inflight[age].v && (inflight[age].r == x)) begin
            if ((age == 0) || ((age == 1) && inflight[age].ld)) return 3'b100;
            return {1'b0, 2'(age)};
         end
      end
      return 3'b000;
   endfunction

   function automatic logic modelStall();
      logic [2:0] a;
      logic [2:0] b;
      a = opScan(id_uses_rs, rs);
      b = opScan(id_uses_rt, rt);
      return a[2] | b[2] | ((busyLeft > 0) && id_valid && (id_is_muldiv || id_reads_hilo));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight[0] <= '0;
         inflight[1] <= '0;
         inflight[2] <= '0;
         busyLeft    <= 0;
         scModel     <= 0;
      end else begin
         inflight[0] <= '{id_valid && id_wr_en && !modelStall(), id_wr_reg, id_is_load};
         inflight[1] <= inflight[0];
         inflight[2] <= inflight[1];
         if (busyLeft > 0) busyLeft <= busyLeft - 1;
         else if (id_valid && id_is_muldiv && !modelStall()) busyLeft <= MD_LATENCY;
         if (modelStall() && (scModel < SC_MAX)) scModel <= scModel + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareModel();
      logic [2:0] a;
      logic [2:0] b;
      logic       eStall;
      logic       eBusy;
      int         eCount;
      a = opScan(id_uses_rs, rs);
      b = opScan(id_uses_rt, rt);
      if (reset) begin
         a = 3'b000;
         b = 3'b000;
         eStall = 1'b0;
         eBusy  = 1'b0;
         eCount = 0;
      end else begin
         eStall = modelStall();
         eBusy  = busyLeft > 0;
         eCount = scModel;
      end
      checkOutput("model_stall", 32'(stall), 32'(eStall));
      checkOutput("model_ex_bubble", 32'(ex_bubble), 32'(eStall));
      checkOutput("model_fwd_a", 32'(fwd_a_sel), 32'(a[1:0]));
      checkOutput("model_fwd_b", 32'(fwd_b_sel), 32'(b[1:0]));
      checkOutput("model_md_busy", 32'(md_busy), 32'(eBusy));
      checkOutput("model_stall_count", 32'(stall_count), 32'(eCount));
   endtask

   task automatic driveInputs(input logic v, input logic [4:0] s, input logic [4:0] t,
                              input logic us, input logic ut, input logic w,
                              input logic [4:0] wr, input logic ld, input logic md, input logic hi);
      id_valid      = v;
      rs            = s;
      rt            = t;
      id_uses_rs    = us;
      id_uses_rt    = ut;
      id_wr_en      = w;
      id_wr_reg     = wr;
      id_is_load    = ld;
      id_is_muldiv  = md;
      id_reads_hilo = hi;
   endtask

   // Present one decode-stage instruction for a cycle and compare against the model mid-cycle.
   task automatic applyStimulus(input logic v, input logic [4:0] s, input logic [4:0] t,
                                input logic us, input logic ut, input logic w,
                                input logic [4:0] wr, input logic ld, input logic md, input logic hi);
      @(posedge clk);
      #1;
      driveInputs(v, s, t, us, ut, w, wr, ld, md, hi);
      @(negedge clk);
      #1;
      compareModel();
   endtask

   task automatic nop();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alu(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      applyStimulus(1'b1, s, t, 1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reader(input logic [4:0] s, input logic [4:0] t);
      applyStimulus(1'b1, s, t, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mult(input logic w, input logic [4:0] d);
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, w, d, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic mfhi();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      driveInputs(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      compareModel();
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_count", 32'(stall_count), 32'd0);
      reset = 1'b0;

      // ALU producer one ahead of a branch: one stall, then MEM forward.
      alu(5'd1, 5'd2, 5'd3);
      reader(5'd3, 5'd0);
      checkOutput("alu_use_stall", 32'(stall), 32'd1);
      checkOutput("alu_use_count0", 32'(stall_count), 32'd0);
      reader(5'd3, 5'd0);
      checkOutput("alu_use_fwd_a", 32'(fwd_a_sel), 32'd1);
      checkOutput("alu_use_clear", 32'(stall), 32'd0);
      checkOutput("alu_use_count1", 32'(stall_count), 32'd1);

      // Load-use on rt: two stalls, then WB forward.
      repeat (3) nop();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      alu(5'd4, 5'd5, 5'd6);
      checkOutput("load_use_stall1", 32'(stall), 32'd1);
      alu(5'd4, 5'd5, 5'd6);
      checkOutput("load_use_stall2", 32'(stall), 32'd1);
      alu(5'd4, 5'd5, 5'd6);
      checkOutput("load_use_fwd_b", 32'(fwd_b_sel), 32'd2);
      checkOutput("load_use_clear", 32'(stall), 32'd0);
      checkOutput("load_use_count", 32'(stall_count), 32'd3);

      // $0 never hazards or forwards.
      repeat (3) nop();
      alu(5'd1, 5'd2, 5'd0);
      reader(5'd0, 5'd0);
      checkOutput("zero_stall", 32'(stall), 32'd0);
      reader(5'd0, 5'd0);
      checkOutput("zero_fwd_a", 32'(fwd_a_sel), 32'd0);
      checkOutput("zero_fwd_b", 32'(fwd_b_sel), 32'd0);

      // mult followed by mfhi stalls exactly MD_LATENCY cycles.
      repeat (3) nop();
      mult(1'b0, 5'd0);
      checkOutput("mult_issue_busy", 32'(md_busy), 32'd0);
      for (int i = 0; i < MD_LATENCY; i++) begin
         mfhi();
         checkOutput("mfhi_stall", 32'(stall), 32'd1);
         checkOutput("mfhi_busy", 32'(md_busy), 32'd1);
      end
      mfhi();
      checkOutput("mfhi_release", 32'(stall), 32'd0);
      checkOutput("mfhi_idle", 32'(md_busy), 32'd0);
      checkOutput("mfhi_count", 32'(stall_count), 32'd7);

      // Youngest producer wins; WB-only producer gives sel 2.
      repeat (3) nop();
      alu(5'd1, 5'd2, 5'd7);
      alu(5'd1, 5'd2, 5'd7);
      nop();
      reader(5'd7, 5'd7);
      checkOutput("youngest_fwd_a", 32'(fwd_a_sel), 32'd1);
      checkOutput("youngest_fwd_b", 32'(fwd_b_sel), 32'd1);
      repeat (3) nop();
      alu(5'd1, 5'd2, 5'd8);
      nop();
      nop();
      reader(5'd8, 5'd0);
      checkOutput("wb_fwd_a", 32'(fwd_a_sel), 32'd2);

      // rs==rt both hazarding counts as a single stall.
      repeat (3) nop();
      alu(5'd1, 5'd2, 5'd12);
      reader(5'd12, 5'd12);
      checkOutput("dual_stall", 32'(stall), 32'd1);
      reader(5'd12, 5'd12);
      checkOutput("dual_fwd_a", 32'(fwd_a_sel), 32'd1);
      checkOutput("dual_fwd_b", 32'(fwd_b_sel), 32'd1);
      checkOutput("dual_count", 32'(stall_count), 32'd8);

      // Reset mid-BUSY with a producer in MEM aborts everything at once.
      repeat (3) nop();
      mult(1'b1, 5'd11);
      nop();
      mfhi();
      checkOutput("pre_reset_stall", 32'(stall), 32'd1);
      checkOutput("pre_reset_busy", 32'(md_busy), 32'd1);
      reset = 1'b1;
      #1;
      compareModel();
      checkOutput("reset_now_stall", 32'(stall), 32'd0);
      checkOutput("reset_now_bubble", 32'(ex_bubble), 32'd0);
      checkOutput("reset_now_busy", 32'(md_busy), 32'd0);
      checkOutput("reset_now_count", 32'(stall_count), 32'd0);
      driveInputs(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      compareModel();
      reset = 1'b0;
      applyStimulus(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_fwd_a", 32'(fwd_a_sel), 32'd0);
      checkOutput("post_reset_stall", 32'(stall), 32'd0);
      checkOutput("post_reset_busy", 32'(md_busy), 32'd0);
      checkOutput("post_reset_count", 32'(stall_count), 32'd0);

      // Saturation of the narrow stall counter.
      for (int round = 0; round < 4; round++) begin
         mult(1'b0, 5'd0);
         repeat (MD_LATENCY + 1) mfhi();
         if (round == 2) checkOutput("sat_count_12", 32'(stall_count), 32'd12);
      end
      checkOutput("sat_count_max", 32'(stall_count), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
